// File: rtl/spi_ip_pkg.sv
// rtl/spi_ip_pkg.sv - shared state encoding and edge-select constants for the SPI slave engine
package spi_ip_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam logic EDGE_LEADING  = 1'b0;
  localparam logic EDGE_TRAILING = 1'b1;

  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  function automatic logic sample_edge_sel(input logic cpha);
    return cpha ? EDGE_TRAILING : EDGE_LEADING;
  endfunction

endpackage

// File: rtl/spi_ip_sync_edge.sv
// rtl/spi_ip_sync_edge.sv - multi-flop synchronizer with rise/fall pulses on the synchronized level
module spi_ip_sync_edge
  import spi_ip_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_ip_slave_shift.sv
// rtl/spi_ip_slave_shift.sv - SPI slave serial engine: oversampled SCK/SS_n, word shift in/out, valid/ready word ports
module spi_ip_slave_shift
  import spi_ip_pkg::*;
#(
  parameter int PARAM_DATA_WIDTH  = 8,
  parameter int PARAM_SYNC_STAGES = 2
) (
  input  logic                        spis_clk_i,
  input  logic                        spis_rst_i,
  input  logic                        spis_sck_i,
  input  logic                        spis_ss_n_i,
  input  logic                        spis_mosi_i,
  output logic                        spis_miso_o,
  output logic                        spis_miso_oe_o,
  input  logic                        spis_cpol_i,
  input  logic                        spis_cpha_i,
  input  logic                        spis_lsb_first_i,
  input  logic [PARAM_DATA_WIDTH-1:0] spis_tx_data_i,
  input  logic                        spis_tx_valid_i,
  output logic                        spis_tx_ready_o,
  output logic [PARAM_DATA_WIDTH-1:0] spis_rx_data_o,
  output logic                        spis_rx_valid_o,
  input  logic                        spis_rx_ready_i,
  input  logic                        spis_clr_err_i,
  output logic                        spis_overrun_o,
  output logic                        spis_underrun_o,
  output logic                        spis_busy_o
);

  localparam int W  = PARAM_DATA_WIDTH;
  localparam int CW = $clog2(W);

  spi_state_e state_q, state_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [W-1:0] hold_q, hold_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic overrun_q, overrun_d, underrun_q, underrun_d;
  logic miso_q, miso_d, skip_q, skip_d, armed_q, armed_d;
  logic lead_q, lead_d, trail_q, trail_d, mosi_q, mosi_d;
  logic [PARAM_SYNC_STAGES:0] settle_q, settle_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic sck_lvl, sck_rise, sck_fall, ss_lvl, ss_rise, ss_fall, mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;
  logic load, tx_ready, sample_ev, shift_ev, cpha_eff, lsb_eff;
  logic [W-1:0] rx_word, load_word;

  spi_ip_sync_edge #(.STAGES(PARAM_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(spis_clk_i), .rst_i(spis_rst_i), .d_i(spis_sck_i),
    .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));
  spi_ip_sync_edge #(.STAGES(PARAM_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i(spis_clk_i), .rst_i(spis_rst_i), .d_i(spis_ss_n_i),
    .q_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_ip_sync_edge #(.STAGES(PARAM_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(spis_clk_i), .rst_i(spis_rst_i), .d_i(spis_mosi_i),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};

  always_comb begin
    state_d = state_q;  cpol_d = cpol_q;  cpha_d = cpha_q;  lsb_d = lsb_q;
    hold_d = hold_q;  hold_full_d = hold_full_q;  tx_sh_d = tx_sh_q;  rx_sh_d = rx_sh_q;
    rx_data_d = rx_data_q;  rx_valid_d = rx_valid_q;  overrun_d = overrun_q;  underrun_d = underrun_q;
    miso_d = miso_q;  skip_d = skip_q;  cnt_d = cnt_q;
    load = 1'b0;
    load_word = '0;
    // Edge pulses are registered once more so MOSI and SCK stay aligned through the same delay.
    lead_d  = cpol_q ? sck_fall : sck_rise;
    trail_d = cpol_q ? sck_rise : sck_fall;
    mosi_d  = mosi_s;
    // Right after reset the SS_n synchronizer still holds its preset; only arm once the pin is seen high.
    settle_d = {settle_q[PARAM_SYNC_STAGES-1:0], 1'b1};
    armed_d  = armed_q | (settle_q[PARAM_SYNC_STAGES] & ss_lvl);
    cpha_eff = (state_q == IDLE) ? spis_cpha_i : cpha_q;
    lsb_eff  = (state_q == IDLE) ? spis_lsb_first_i : lsb_q;
    sample_ev = (sample_edge_sel(cpha_q) == EDGE_LEADING) ? lead_q : trail_q;
    shift_ev  = (sample_edge_sel(cpha_q) == EDGE_LEADING) ? trail_q : lead_q;
    rx_word   = lsb_q ? {mosi_q, rx_sh_q[W-1:1]} : {rx_sh_q[W-2:0], mosi_q};

    if (rx_valid_q && spis_rx_ready_i) rx_valid_d = 1'b0;
    if (spis_clr_err_i) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          state_d = ACTIVE;
          cpol_d  = spis_cpol_i;
          cpha_d  = spis_cpha_i;
          lsb_d   = spis_lsb_first_i;
          cnt_d   = '0;
          rx_sh_d = '0;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
          skip_d  = 1'b0;
        end else begin
          if (sample_ev) begin
            rx_sh_d = rx_word;
            if (cnt_q == CW'(W - 1)) begin
              cnt_d = '0;
              load  = 1'b1;
              if (!rx_valid_q || spis_rx_ready_i) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (shift_ev) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              miso_d  = lsb_q ? tx_sh_q[0] : tx_sh_q[W-1];
              tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_ready = ~hold_full_q | load;
    if (load) begin
      load_word   = hold_full_q ? hold_q : '0;
      hold_full_d = 1'b0;
      if (!hold_full_q) underrun_d = 1'b1;
      // CPHA=0 presents bit 0 immediately; a mid-stream reload must ignore the word's last trailing edge.
      if (!cpha_eff) begin
        miso_d  = lsb_eff ? load_word[0] : load_word[W-1];
        tx_sh_d = lsb_eff ? (load_word >> 1) : (load_word << 1);
        skip_d  = (state_q == ACTIVE);
      end else begin
        tx_sh_d = load_word;
      end
    end
    if (spis_tx_valid_i && tx_ready) begin
      hold_d      = spis_tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge spis_clk_i) begin
    if (spis_rst_i) begin
      state_q <= IDLE;  cpol_q <= 1'b0;  cpha_q <= 1'b0;  lsb_q <= 1'b0;
      hold_q <= '0;  hold_full_q <= 1'b0;  tx_sh_q <= '0;  rx_sh_q <= '0;
      rx_data_q <= '0;  rx_valid_q <= 1'b0;  overrun_q <= 1'b0;  underrun_q <= 1'b0;
      miso_q <= 1'b0;  skip_q <= 1'b0;  armed_q <= 1'b0;  cnt_q <= '0;
      lead_q <= 1'b0;  trail_q <= 1'b0;  mosi_q <= 1'b0;  settle_q <= '0;
    end else begin
      state_q <= state_d;  cpol_q <= cpol_d;  cpha_q <= cpha_d;  lsb_q <= lsb_d;
      hold_q <= hold_d;  hold_full_q <= hold_full_d;  tx_sh_q <= tx_sh_d;  rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;  rx_valid_q <= rx_valid_d;  overrun_q <= overrun_d;  underrun_q <= underrun_d;
      miso_q <= miso_d;  skip_q <= skip_d;  armed_q <= armed_d;  cnt_q <= cnt_d;
      lead_q <= lead_d;  trail_q <= trail_d;  mosi_q <= mosi_d;  settle_q <= settle_d;
    end
  end

  assign spis_miso_o     = miso_q;
  assign spis_miso_oe_o  = (state_q == ACTIVE);
  assign spis_busy_o     = (state_q == ACTIVE);
  assign spis_tx_ready_o = tx_ready;
  assign spis_rx_data_o  = rx_data_q;
  assign spis_rx_valid_o = rx_valid_q;
  assign spis_overrun_o  = overrun_q;
  assign spis_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_ip_slave_shift.sv
// tb/tb_spi_ip_slave_shift.sv - table-driven and scoreboard bench for spi_ip_slave_shift
module tb_spi_ip_slave_shift;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst, sck, ss_n, mosi, cpol, cpha, lsb, tx_valid, rx_ready, clr_err;
  logic [W-1:0] tx_data, rx_data;
  logic miso, miso_oe, tx_ready, rx_valid, overrun, underrun, busy;

  spi_ip_slave_shift #(.PARAM_DATA_WIDTH(W), .PARAM_SYNC_STAGES(SS)) dut (
    .spis_clk_i(clk), .spis_rst_i(rst), .spis_sck_i(sck), .spis_ss_n_i(ss_n),
    .spis_mosi_i(mosi), .spis_miso_o(miso), .spis_miso_oe_o(miso_oe),
    .spis_cpol_i(cpol), .spis_cpha_i(cpha), .spis_lsb_first_i(lsb),
    .spis_tx_data_i(tx_data), .spis_tx_valid_i(tx_valid), .spis_tx_ready_o(tx_ready),
    .spis_rx_data_o(rx_data), .spis_rx_valid_o(rx_valid), .spis_rx_ready_i(rx_ready),
    .spis_clr_err_i(clr_err), .spis_overrun_o(overrun), .spis_underrun_o(underrun),
    .spis_busy_o(busy));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] mon_exp;

  typedef struct {
    logic cpol, cpha, lsb, has_tx;
    logic [W-1:0] tx, mo, exp_mi;
    logic exp_ur;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      rx_cnt++;
      if (exp_rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%0h expected=none", rx_data);
      end else begin
        mon_exp = exp_rx_q.pop_front();
        check("rx_data", rx_data, mon_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [W-1:0] d);
    int n;
    n = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL tx_push_timeout actual=%0d expected=<200", n);
    end
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic ss_fall_t();
    sck = cpol;
    ss_n = 1'b0;
    tick(H);
  endtask

  task automatic ss_rise_t();
    tick(H);
    ss_n = 1'b1;
    tick(H);
  endtask

  task automatic spi_word(input logic [W-1:0] mo, input int nbits, input bit expect_rx,
                          output logic [W-1:0] mi);
    mi = '0;
    if (expect_rx) exp_rx_q.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb ? i : W - 1 - i;
      if (!cpha) begin
        mosi = mo[idx];
        tick(H);
        sck = ~cpol;
        mi[idx] = miso;
        tick(H);
        sck = cpol;
      end else begin
        tick(H);
        sck = ~cpol;
        mosi = mo[idx];
        tick(H);
        sck = cpol;
        mi[idx] = miso;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] mi;
    int base;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h81, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 8'hC3, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 8'h96, 8'h5A, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hE7, 8'h00, 1'b1};

    rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1; clr_err = 1'b0;
    tick(4);
    check("rst_miso", miso, 0);
    check("rst_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(H);

    for (int v = 0; v < 5; v++) begin
      clear_err();
      cpol = vecs[v].cpol; cpha = vecs[v].cpha; lsb = vecs[v].lsb;
      sck = cpol;
      tick(H);
      base = rx_cnt;
      if (vecs[v].has_tx) begin
        push_tx(vecs[v].tx);
        check("vec_tx_ready_full", tx_ready, 0);
      end
      ss_fall_t();
      check("vec_busy", busy, 1);
      check("vec_oe", miso_oe, 1);
      if (vecs[v].has_tx) begin
        check("vec_tx_ready_freed", tx_ready, 1);
        push_tx(8'hFF);
      end
      spi_word(vecs[v].mo, W, 1'b1, mi);
      check("vec_miso_word", mi, vecs[v].exp_mi);
      ss_rise_t();
      check("vec_underrun", underrun, vecs[v].exp_ur);
      check("vec_rx_count", rx_cnt - base, 1);
      check("vec_oe_idle", miso_oe, 0);
      check("vec_busy_idle", busy, 0);
    end

    // Back-to-back words with rx_ready low: second word overruns.
    clear_err();
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sck = 1'b0; rx_ready = 1'b0;
    tick(H);
    base = rx_cnt;
    push_tx(8'h96);
    ss_fall_t();
    push_tx(8'h69);
    spi_word(8'h11, W, 1'b1, mi);
    check("b2b_miso0", mi, 8'h96);
    spi_word(8'h22, W, 1'b0, mi);
    check("b2b_miso1", mi, 8'h69);
    ss_rise_t();
    check("b2b_rx_valid", rx_valid, 1);
    check("b2b_rx_data", rx_data, 8'h11);
    check("b2b_overrun", overrun, 1);
    check("b2b_underrun", underrun, 1);
    clear_err();
    check("b2b_overrun_clr", overrun, 0);
    check("b2b_underrun_clr", underrun, 0);
    rx_ready = 1'b1;
    tick(2);
    check("b2b_rx_valid_drop", rx_valid, 0);
    check("b2b_rx_count", rx_cnt - base, 1);

    // SS_n released after 5 SCK edges.
    base = rx_cnt;
    push_tx(8'hEE);
    ss_fall_t();
    for (int e = 0; e < 5; e++) begin
      tick(H);
      sck = ~sck;
    end
    tick(2);
    ss_n = 1'b1;
    tick(SS);
    check("partial_oe_hold", miso_oe, 1);
    tick(1);
    check("partial_oe_drop", miso_oe, 0);
    check("partial_miso_zero", miso, 0);
    check("partial_busy", busy, 0);
    sck = cpol;
    tick(H);
    check("partial_no_rx", rx_cnt - base, 0);
    push_tx(8'hC3);
    ss_fall_t();
    spi_word(8'h6B, W, 1'b1, mi);
    check("partial_next_miso", mi, 8'hC3);
    ss_rise_t();
    check("partial_next_rx", rx_cnt - base, 1);

    // Reset during bit 3, with SS_n held low afterwards.
    base = rx_cnt;
    ss_fall_t();
    spi_word(8'h5A, 3, 1'b0, mi);
    tick(H / 2);
    check("pre_rst_underrun", underrun, 1);
    rst = 1'b1;
    tick(1);
    check("midrst_miso", miso, 0);
    check("midrst_oe", miso_oe, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    spi_word(8'h5A, 5, 1'b0, mi);
    check("postrst_busy", busy, 0);
    ss_rise_t();
    check("postrst_no_rx", rx_cnt - base, 0);
    push_tx(8'h3C);
    ss_fall_t();
    spi_word(8'hD2, W, 1'b1, mi);
    check("postrst_miso", mi, 8'h3C);
    ss_rise_t();
    check("postrst_rx", rx_cnt - base, 1);

    tick(H);
    check("scoreboard_drain", exp_rx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
